// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: receive-side RMII framer, 100 Mb/s (one dibit per clk).
// Strips preamble/SFD, assembles bytes LSB-first, checks CRC-32 and length, and delivers
// a byte stream with end-of-frame status.
//
// Ports:
//   clk, resetn            : 50 MHz clock, asynchronous active-low reset
//   crs_dv, rx_d, rx_er    : RMII receive pins (registered once before use)
//   m_data/m_valid/m_last  : byte stream, no backpressure
//   frame_done             : one-cycle pulse at end of every frame that reached DATA
//   frame_len, crc_ok, rx_err, len_err, align_err : status, valid with frame_done, held after
module rmii_rx_framer #(
  parameter int unsigned MIN_PREAMBLE = 8,
  parameter int unsigned MIN_LEN      = 64,
  parameter int unsigned MAX_LEN      = 1518,
  parameter logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        crs_dv,
  input  logic [1:0]  rx_d,
  input  logic        rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic        crc_ok,
  output logic        rx_err,
  output logic        len_err,
  output logic        align_err
);

  localparam logic [3:0]  MinPre = 4'(MIN_PREAMBLE);
  localparam logic [10:0] MinLen = 11'(MIN_LEN);
  localparam logic [10:0] MaxLen = 11'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StPre, StData, StTrunc, StDrop} state_e;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic        crs_q, rxer_q;
  logic [1:0]  rxd_q;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  sr_q, sr_d, sr_next;
  logic [1:0]  dib_cnt_q, dib_cnt_d;
  logic [7:0]  hold_byte_q, hold_byte_d;
  logic        hold_full_q, hold_full_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        rx_err_flag_q, rx_err_flag_d;
  // One-dibit delay: a low-carrier dibit is only known to be data once the next cycle is high.
  logic [1:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d, pend_low_q, pend_low_d;
  logic        drop_low_q, drop_low_d;
  logic        finish, finish_trunc;

  logic [7:0]  m_data_d;
  logic        m_valid_d, m_last_d, frame_done_d;
  logic [10:0] frame_len_d;
  logic        crc_ok_d, rx_err_d, len_err_d, align_err_d;

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    sr_d          = sr_q;
    sr_next       = {pend_q, sr_q[7:2]};
    dib_cnt_d     = dib_cnt_q;
    hold_byte_d   = hold_byte_q;
    hold_full_d   = hold_full_q;
    byte_cnt_d    = byte_cnt_q;
    crc_d         = crc_q;
    rx_err_flag_d = rx_err_flag_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    pend_low_d    = pend_low_q;
    drop_low_d    = drop_low_q;
    finish        = 1'b0;
    finish_trunc  = 1'b0;
    m_data_d      = m_data;
    m_valid_d     = 1'b0;
    m_last_d      = 1'b0;
    frame_done_d  = 1'b0;
    frame_len_d   = frame_len;
    crc_ok_d      = crc_ok;
    rx_err_d      = rx_err;
    len_err_d     = len_err;
    align_err_d   = align_err;

    unique case (state_q)
      StIdle: begin
        if (crs_q) begin
          state_d   = StPre;
          pre_cnt_d = 4'd0;
        end
      end
      StPre: begin
        if (!crs_q) begin
          state_d = StIdle;
        end else if (rxd_q == 2'b01) begin
          if (pre_cnt_q != 4'd15) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (rxd_q == 2'b00 && pre_cnt_q == 4'd0) begin
          state_d = StPre;
        end else if (rxd_q == 2'b11 && pre_cnt_q >= MinPre) begin
          state_d       = StData;
          sr_d          = 8'h00;
          dib_cnt_d     = 2'd0;
          byte_cnt_d    = 11'd0;
          crc_d         = '1;
          rx_err_flag_d = 1'b0;
          pend_valid_d  = 1'b0;
          pend_low_d    = 1'b0;
          hold_full_d   = 1'b0;
        end else begin
          state_d    = StDrop;
          drop_low_d = 1'b0;
        end
      end
      StData: begin
        if (!crs_q && pend_valid_q && pend_low_q) begin
          // Second consecutive low: end of frame, the pending low dibit is discarded.
          finish  = 1'b1;
          state_d = StIdle;
        end else begin
          if (rxer_q) rx_err_flag_d = 1'b1;
          pend_d       = rxd_q;
          pend_low_d   = !crs_q;
          pend_valid_d = 1'b1;
          if (pend_valid_q) begin
            if (byte_cnt_q == MaxLen) begin
              // Data beyond MAX_LEN after a carrier toggle: truncate now.
              state_d = StTrunc;
            end else begin
              sr_d      = sr_next;
              dib_cnt_d = dib_cnt_q + 2'd1;
              if (dib_cnt_q == 2'd3) begin
                if (hold_full_q) begin
                  m_valid_d = 1'b1;
                  m_data_d  = hold_byte_q;
                end
                hold_byte_d = sr_next;
                hold_full_d = 1'b1;
                crc_d       = crc_byte(crc_q, sr_next);
                byte_cnt_d  = byte_cnt_q + 11'd1;
                if (byte_cnt_q == MaxLen - 11'd1 && crs_q) state_d = StTrunc;
              end
            end
          end
        end
      end
      StTrunc: begin
        finish       = 1'b1;
        finish_trunc = 1'b1;
        state_d      = StDrop;
        drop_low_d   = !crs_q;
      end
      StDrop: begin
        if (!crs_q) begin
          if (drop_low_q) state_d = StIdle;
          drop_low_d = 1'b1;
        end else begin
          drop_low_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      m_valid_d    = hold_full_q;
      m_last_d     = hold_full_q;
      m_data_d     = hold_byte_q;
      hold_full_d  = 1'b0;
      frame_done_d = 1'b1;
      frame_len_d  = byte_cnt_q;
      align_err_d  = (dib_cnt_q != 2'd0);
      crc_ok_d     = (crc_q == CRC_RESIDUE) && (dib_cnt_q == 2'd0);
      len_err_d    = finish_trunc || (byte_cnt_q < MinLen);
      rx_err_d     = rx_err_flag_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crs_q         <= 1'b0;
      rxd_q         <= 2'b00;
      rxer_q        <= 1'b0;
      state_q       <= StIdle;
      pre_cnt_q     <= 4'd0;
      sr_q          <= 8'h00;
      dib_cnt_q     <= 2'd0;
      hold_byte_q   <= 8'h00;
      hold_full_q   <= 1'b0;
      byte_cnt_q    <= 11'd0;
      crc_q         <= '1;
      rx_err_flag_q <= 1'b0;
      pend_q        <= 2'b00;
      pend_valid_q  <= 1'b0;
      pend_low_q    <= 1'b0;
      drop_low_q    <= 1'b0;
      m_data        <= 8'h00;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      frame_done    <= 1'b0;
      frame_len     <= 11'd0;
      crc_ok        <= 1'b0;
      rx_err        <= 1'b0;
      len_err       <= 1'b0;
      align_err     <= 1'b0;
    end else begin
      crs_q         <= crs_dv;
      rxd_q         <= rx_d;
      rxer_q        <= rx_er;
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      sr_q          <= sr_d;
      dib_cnt_q     <= dib_cnt_d;
      hold_byte_q   <= hold_byte_d;
      hold_full_q   <= hold_full_d;
      byte_cnt_q    <= byte_cnt_d;
      crc_q         <= crc_d;
      rx_err_flag_q <= rx_err_flag_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      pend_low_q    <= pend_low_d;
      drop_low_q    <= drop_low_d;
      m_data        <= m_data_d;
      m_valid       <= m_valid_d;
      m_last        <= m_last_d;
      frame_done    <= frame_done_d;
      frame_len     <= frame_len_d;
      crc_ok        <= crc_ok_d;
      rx_err        <= rx_err_d;
      len_err       <= len_err_d;
      align_err     <= align_err_d;
    end
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Self-checking bench for rmii_rx_framer: table of whole-frame vectors plus hand-written
// sequences for MAX_LEN truncation, short preamble and mid-frame reset.
module tb_rmii_rx_framer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        crs_dv = 1'b0;
  logic [1:0]  rx_d = 2'b00;
  logic        rx_er = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_last, frame_done;
  logic [10:0] frame_len;
  logic        crc_ok, rx_err, len_err, align_err;

  rmii_rx_framer dut (
    .clk       (clk),
    .resetn    (resetn),
    .crs_dv    (crs_dv),
    .rx_d      (rx_d),
    .rx_er     (rx_er),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .crc_ok    (crc_ok),
    .rx_err    (rx_err),
    .len_err   (len_err),
    .align_err (align_err)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor state
  logic [7:0] rx_bytes[$];
  logic [7:0] tx_bytes[$];
  int valid_cnt = 0;
  int last_idx = -1;
  int done_cnt = 0;
  int cap_len, cap_crc, cap_rx, cap_lenerr, cap_align;

  always @(negedge clk) begin
    if (m_valid) begin
      rx_bytes.push_back(m_data);
      if (m_last) last_idx = valid_cnt;
      valid_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      cap_len    = int'(frame_len);
      cap_crc    = int'(crc_ok);
      cap_rx     = int'(rx_err);
      cap_lenerr = int'(len_err);
      cap_align  = int'(align_err);
    end
  end

  typedef struct {
    int n_payload;
    bit no_data;
    bit corrupt;
    int extra_dib;
    int er_at;
    int toggle;
    int exp_len;
    bit exp_crc;
    bit exp_len_err;
    bit exp_rx_err;
    bit exp_align;
    int exp_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic drive(input logic c, input logic [1:0] d, input logic e);
    @(posedge clk);
    #2;
    crs_dv = c;
    rx_d   = d;
    rx_er  = e;
  endtask

  task automatic clear_mon();
    rx_bytes.delete();
    valid_cnt = 0;
    last_idx  = -1;
  endtask

  task automatic build_frame(input int n, input bit no_data, input bit corrupt);
    logic [31:0] crc, fcs, t;
    tx_bytes.delete();
    if (!no_data) begin
      crc = '1;
      for (int i = 0; i < n; i++) begin
        tx_bytes.push_back(8'(i));
        crc = crc_upd(crc, 8'(i));
      end
      fcs = ~crc;
      for (int j = 0; j < 4; j++) begin
        t = fcs >> (8 * j);
        if (corrupt && j == 0) t = t ^ 32'hFF;
        tx_bytes.push_back(t[7:0]);
      end
    end
  endtask

  task automatic send_preamble();
    logic [7:0] pb, t;
    for (int b = 0; b < 8; b++) begin
      pb = (b < 7) ? 8'h55 : 8'hD5;
      for (int j = 0; j < 4; j++) begin
        t = pb >> (2 * j);
        drive(1'b1, t[1:0], 1'b0);
      end
    end
  endtask

  // Sends tx_bytes as a frame; toggle drops crs_dv for one data dibit, counted from the end.
  task automatic send_frame(input int extra_dib, input int er_at, input int toggle);
    int n;
    logic [7:0] t;
    send_preamble();
    n = tx_bytes.size() * 4;
    for (int k = 0; k < n; k++) begin
      t = tx_bytes[k / 4] >> (2 * (k % 4));
      drive(!(toggle > 0 && k == n - toggle), t[1:0], k == er_at);
    end
    for (int k = 0; k < extra_dib; k++) drive(1'b1, 2'b10, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic wait_done(input int prev, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != prev) seen = 1'b1;
    end
  endtask

  function automatic int bytes_match(input int n);
    if (rx_bytes.size() != n) return 0;
    for (int i = 0; i < n; i++) if (rx_bytes[i] != tx_bytes[i]) return 0;
    return 1;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int prev;
    bit seen;
    clear_mon();
    build_frame(v.n_payload, v.no_data, v.corrupt);
    prev = done_cnt;
    send_frame(v.extra_dib, v.er_at, v.toggle);
    wait_done(prev, seen);
    repeat (3) @(posedge clk);
    check({tag, ".frame_done"}, int'(seen), 1);
    check({tag, ".done_count"}, done_cnt - prev, 1);
    check({tag, ".frame_len"}, cap_len, v.exp_len);
    check({tag, ".crc_ok"}, cap_crc, int'(v.exp_crc));
    check({tag, ".len_err"}, cap_lenerr, int'(v.exp_len_err));
    check({tag, ".rx_err"}, cap_rx, int'(v.exp_rx_err));
    check({tag, ".align_err"}, cap_align, int'(v.exp_align));
    check({tag, ".valid_count"}, valid_cnt, v.exp_valid);
    check({tag, ".bytes"}, bytes_match(v.exp_valid), 1);
    check({tag, ".last_index"}, last_idx, v.exp_valid - 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int prev;
    bit seen;
    vecs[0] = '{60, 0, 0, 0, -1, 0, 64, 1, 0, 0, 0, 64};   // good frame
    vecs[1] = '{60, 0, 1, 0, -1, 0, 64, 0, 0, 0, 0, 64};   // bad FCS
    vecs[2] = '{20, 0, 0, 0, -1, 0, 24, 1, 1, 0, 0, 24};   // runt
    vecs[3] = '{60, 0, 0, 0, 100, 6, 64, 1, 0, 1, 0, 64};  // rx_er + carrier toggle
    vecs[4] = '{60, 0, 0, 1, -1, 0, 64, 0, 0, 0, 1, 64};   // trailing partial dibit
    vecs[5] = '{0, 1, 0, 0, -1, 0, 0, 0, 1, 0, 0, 0};      // zero-byte frame

    repeat (3) @(posedge clk);
    check("reset_outputs", int'({m_data, m_valid, m_last, frame_done, frame_len, crc_ok,
                                 rx_err, len_err, align_err}), 0);
    #3 resetn = 1'b1;
    repeat (3) @(posedge clk);
    check("post_reset_outputs", int'({m_data, m_valid, m_last, frame_done, frame_len,
                                      crc_ok, rx_err, len_err, align_err}), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // MAX_LEN truncation: 2000-byte stream
    clear_mon();
    tx_bytes.delete();
    for (int i = 0; i < 2000; i++) tx_bytes.push_back(8'(i));
    prev = done_cnt;
    send_frame(0, -1, 0);
    repeat (10) @(posedge clk);
    check("trunc.done_count", done_cnt - prev, 1);
    check("trunc.frame_len", cap_len, 1518);
    check("trunc.len_err", cap_lenerr, 1);
    check("trunc.align_err", cap_align, 0);
    check("trunc.valid_count", valid_cnt, 1518);
    check("trunc.last_index", last_idx, 1517);
    check("trunc.bytes", bytes_match(1518), 1);
    run_vec(vecs[0], "after_trunc");

    // Preamble too short: 01 01 01 11 -> DROP
    clear_mon();
    prev = done_cnt;
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    for (int k = 0; k < 40; k++) drive(1'b1, 2'(k), 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    repeat (10) @(posedge clk);
    check("short_pre.done_count", done_cnt - prev, 0);
    check("short_pre.valid_count", valid_cnt, 0);

    // Reset asserted mid-DATA: outputs clear at once, frame discarded
    clear_mon();
    build_frame(60, 0, 0);
    prev = done_cnt;
    send_preamble();
    for (int k = 0; k < 120; k++) begin
      logic [7:0] t;
      t = tx_bytes[k / 4] >> (2 * (k % 4));
      drive(1'b1, t[1:0], 1'b0);
    end
    check("mid_reset.bytes_before", int'(valid_cnt > 0), 1);
    #3 resetn = 1'b0;
    #1;
    check("mid_reset.outputs", int'({m_data, m_valid, m_last, frame_done, frame_len, crc_ok,
                                     rx_err, len_err, align_err}), 0);
    crs_dv = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (10) @(posedge clk);
    check("mid_reset.done_count", done_cnt - prev, 0);
    run_vec(vecs[0], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
